// File: rtl/track_mode_selector.sv
// Track mode selector: synchronised, debounced push-button with post-press lockout,
// cycling through modes with an arming countdown that ends in a start command.
module track_mode_selector #(
    parameter int N_MODES         = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LOCKOUT_CYCLES  = 50_000_000,
    parameter int ARM_CYCLES      = 250_000_000,
    localparam int MODE_W         = $clog2(N_MODES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_sel,
    input  logic              stop_i,
    output logic [MODE_W-1:0] mode,
    output logic [N_MODES-1:0] mode_led,
    output logic              arming,
    output logic              running,
    output logic              start_pulse,
    output logic [1:0]        o_dbg_state
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int LO_W  = $clog2(LOCKOUT_CYCLES) + 1;
    localparam int ARM_W = $clog2(ARM_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMING = 2'd1,
        S_RUN    = 2'd2
    } state_e;

    logic [1:0]         r_sync;
    logic               r_db_level;
    logic [DB_W-1:0]    r_db_cnt;
    logic [LO_W-1:0]    r_lock_cnt;
    state_e             r_state;
    logic [MODE_W-1:0]  r_mode;
    logic [ARM_W-1:0]   r_arm_cnt;
    logic [N_MODES-1:0] r_mode_led;
    logic               r_arming;
    logic               r_running;
    logic               r_start_pulse;

    logic               w_db_diff;
    logic               w_db_flip;
    logic               w_press;
    state_e             w_state_nx;
    logic [MODE_W-1:0]  w_mode_nx;
    logic [ARM_W-1:0]   w_arm_nx;
    logic               w_start_nx;
    logic [N_MODES-1:0] w_led_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_sel};
        end
    end

    // The debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign w_db_diff = (r_sync[1] != r_db_level);
    assign w_db_flip = w_db_diff && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign w_press   = w_db_flip && !r_db_level && (r_lock_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else if (!w_db_diff) begin
            r_db_cnt   <= '0;
        end else if (w_db_flip) begin
            r_db_level <= ~r_db_level;
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt   <= r_db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
        end else if (w_press) begin
            r_lock_cnt <= LO_W'(LOCKOUT_CYCLES);
        end else if (r_lock_cnt != '0) begin
            r_lock_cnt <= r_lock_cnt - LO_W'(1);
        end
    end

    // Priority: stop_i, then press, then countdown expiry.
    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_arm_nx   = r_arm_cnt;
        w_start_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_state_nx = S_ARMING;
                    w_mode_nx  = MODE_W'(1);
                    w_arm_nx   = ARM_W'(ARM_CYCLES - 1);
                end
            end
            S_ARMING: begin
                if (stop_i) begin
                    w_state_nx = S_IDLE;
                    w_mode_nx  = '0;
                    w_arm_nx   = '0;
                end else if (w_press) begin
                    if (r_mode == MODE_W'(N_MODES)) begin
                        w_state_nx = S_IDLE;
                        w_mode_nx  = '0;
                        w_arm_nx   = '0;
                    end else begin
                        w_mode_nx  = r_mode + MODE_W'(1);
                        w_arm_nx   = ARM_W'(ARM_CYCLES - 1);
                    end
                end else if (r_arm_cnt == '0) begin
                    w_state_nx = S_RUN;
                    w_start_nx = 1'b1;
                end else begin
                    w_arm_nx   = r_arm_cnt - ARM_W'(1);
                end
            end
            S_RUN: begin
                if (stop_i || w_press) begin
                    w_state_nx = S_IDLE;
                    w_mode_nx  = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_mode_nx  = '0;
                w_arm_nx   = '0;
            end
        endcase
    end

    always_comb begin
        w_led_nx = '0;
        for (int i = 0; i < N_MODES; i++) begin
            w_led_nx[i] = (w_mode_nx == MODE_W'(i + 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_mode        <= '0;
            r_arm_cnt     <= '0;
            r_mode_led    <= '0;
            r_arming      <= 1'b0;
            r_running     <= 1'b0;
            r_start_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_mode        <= w_mode_nx;
            r_arm_cnt     <= w_arm_nx;
            r_mode_led    <= w_led_nx;
            r_arming      <= (w_state_nx == S_ARMING);
            r_running     <= (w_state_nx == S_RUN);
            r_start_pulse <= w_start_nx;
        end
    end

    assign mode        = r_mode;
    assign mode_led    = r_mode_led;
    assign arming      = r_arming;
    assign running     = r_running;
    assign start_pulse = r_start_pulse;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_track_mode_selector.sv
// Bench for track_mode_selector: button bounce, lockout, mode wrap, arming/start,
// abort and mid-arming reset, checked through an expected-snapshot queue.
module tb_track_mode_selector;

    localparam int N_MODES = 3;
    localparam int DB      = 4;
    localparam int LO      = 20;
    localparam int ARM     = 50;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMING = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic       clk;
    logic       rst_n;
    logic       btn_sel;
    logic       stop_i;
    logic [1:0] mode;
    logic [2:0] mode_led;
    logic       arming;
    logic       running;
    logic       start_pulse;
    logic [1:0] dbg_state;

    logic [9:0] exp_q[$];
    int         n_total;
    int         n_bad;
    int         start_seen;
    int         exp_starts;
    int         run_wait;

    track_mode_selector #(
        .N_MODES        (N_MODES),
        .DEBOUNCE_CYCLES(DB),
        .LOCKOUT_CYCLES (LO),
        .ARM_CYCLES     (ARM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_sel    (btn_sel),
        .stop_i     (stop_i),
        .mode       (mode),
        .mode_led   (mode_led),
        .arming     (arming),
        .running    (running),
        .start_pulse(start_pulse),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (start_pulse === 1'b1) start_seen++;
    end

    function automatic logic [9:0] snap(input logic [1:0] st, input logic [1:0] md,
                                        input logic ar, input logic ru, input logic sp);
        logic [2:0] led;
        led = 3'b000;
        if (md != 2'd0) led[md - 2'd1] = 1'b1;
        return {st, md, led, ar, ru, sp};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard
    task automatic push_exp(input logic [9:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s got=queue_empty exp=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {22'd0, dbg_state, mode, mode_led, arming, running, start_pulse}, {22'd0, e});
        end
    endtask

    // drivers
    task automatic press(input int hold, input int gap);
        btn_sel = 1'b1;
        repeat (hold) @(negedge clk);
        btn_sel = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (running !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        start_seen = 0;
        exp_starts = 0;
        rst_n      = 1'b0;
        btn_sel    = 1'b0;
        stop_i     = 1'b0;

        repeat (3) @(negedge clk);
        push_exp(snap(ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
        check_pop("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(snap(ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
        check_pop("reset_release");

        // bounce: toggling every 2 cycles must never pass the debouncer
        for (int i = 0; i < 10; i++) begin
            btn_sel = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        push_exp(snap(ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
        check_pop("bounce_idle");
        push_exp(snap(ST_ARMING, 2'd1, 1'b1, 1'b0, 1'b0));
        btn_sel = 1'b1;
        repeat (10) @(negedge clk);
        check_pop("bounce_press");
        push_exp(snap(ST_ARMING, 2'd1, 1'b1, 1'b0, 1'b0));
        btn_sel = 1'b0;
        repeat (8) @(negedge clk);
        check_pop("bounce_release");
        push_exp(snap(ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
        pulse_stop();
        check_pop("bounce_stop");
        repeat (25) @(negedge clk);

        // lockout: second press 10 cycles later ignored, third at 30 accepted
        push_exp(snap(ST_ARMING, 2'd1, 1'b1, 1'b0, 1'b0));
        press(6, 4);
        press(6, 14);
        check_pop("lockout_ignored");
        push_exp(snap(ST_ARMING, 2'd2, 1'b1, 1'b0, 1'b0));
        press(8, 8);
        check_pop("lockout_accepted");

        // arm/start: countdown reloaded by the accepted press (entry 10 cycles ago)
        wait_run(run_wait);
        check("run_latency", run_wait, ARM - 10);
        exp_starts++;
        push_exp(snap(ST_RUN, 2'd2, 1'b0, 1'b1, 1'b1));
        check_pop("start_cycle");
        push_exp(snap(ST_RUN, 2'd2, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        check_pop("run_hold");
        push_exp(snap(ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
        pulse_stop();
        check_pop("abort_run");
        repeat (25) @(negedge clk);

        // wrap: 1, 2, 3, then back to 0 / IDLE
        for (int m = 1; m <= 4; m++) begin
            if (m == 4) push_exp(snap(ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
            else        push_exp(snap(ST_ARMING, 2'(m), 1'b1, 1'b0, 1'b0));
            press(8, 16);
            check_pop($sformatf("wrap_%0d", m));
        end
        repeat (25) @(negedge clk);

        // abort on the exact expiry cycle: no start pulse
        push_exp(snap(ST_ARMING, 2'd1, 1'b1, 1'b0, 1'b0));
        press(8, 8);
        check_pop("expiry_arm");
        repeat (ARM - 11) @(negedge clk);
        push_exp(snap(ST_ARMING, 2'd1, 1'b1, 1'b0, 1'b0));
        check_pop("pre_expiry");
        push_exp(snap(ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
        pulse_stop();
        check_pop("abort_expiry");
        push_exp(snap(ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
        repeat (60) @(negedge clk);
        check_pop("expiry_settled");

        // reset mid-arming: asynchronous clear, stays idle afterwards
        push_exp(snap(ST_ARMING, 2'd1, 1'b1, 1'b0, 1'b0));
        press(8, 8);
        check_pop("reset_arm");
        #2 rst_n = 1'b0;
        #1;
        push_exp(snap(ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
        check_pop("reset_async");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_exp(snap(ST_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
        repeat (60) @(negedge clk);
        check_pop("reset_after");

        check("start_count", start_seen, exp_starts);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/track_mode_selector.md
# track_mode_selector

Selects the track mode (straight line, curves, endurance, …) from a single raw push-button, with synchronisation, debounce and a post-press lockout. Shows the selected mode on one-hot LEDs and runs an arming countdown after each selection. When the countdown expires it issues the start command to the drive controller. Sits between the board button/LEDs and the motion FSM; replaces the unclocked, undebounced selector.

## Interface
- `N_MODES`, 3: number of selectable modes; mode 0 = inactive; legal range ≥1.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronised samples required to accept a button level change (20 ms @ 50 MHz); ≥1.
- `LOCKOUT_CYCLES`, 50_000_000: after an accepted press, further presses are ignored for this many cycles (1 s @ 50 MHz); ≥1.
- `ARM_CYCLES`, 250_000_000: arming countdown length (5 s @ 50 MHz); ≥1.
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn_sel`, in, 1: raw, asynchronous mode-select button, active high.
- `stop_i`, in, 1: synchronous abort from the motion FSM (lap done / fault), active high.
- `mode`, out, MODE_W = $clog2(N_MODES+1): current mode, 0..N_MODES.
- `mode_led`, out, N_MODES: one-hot; `mode_led[i]` = (mode == i+1); all zero when mode = 0.
- `arming`, out, 1: high while the countdown runs.
- `running`, out, 1: high while the car is commanded to move.
- `start_pulse`, out, 1: one-cycle pulse on the first cycle of RUN.

## Operation
- Input path: 2-flop synchroniser → debouncer.
  - The debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any reversion restarts the count.
  - Releases are debounced the same way.
- Press event = rising edge of the debounced level, accepted only if the lockout counter is 0.
- An accepted press loads the lockout counter with LOCKOUT_CYCLES. The counter decrements to 0 each cycle; events that arrive while it is nonzero are discarded.
- FSM states: IDLE, ARMING, RUN.
  - IDLE, press: mode←1, countdown←ARM_CYCLES−1, go to ARMING.
  - ARMING, press: mode←(mode==N_MODES)?0:mode+1. If the new mode is 0, go to IDLE; otherwise reload the countdown and stay in ARMING.
  - ARMING, no press, countdown==0: go to RUN, start_pulse←1. Otherwise the countdown decrements.
  - RUN, press: go to IDLE, mode←0.
  - stop_i in ARMING or RUN: go to IDLE, mode←0.
  - Priority: stop_i > press > countdown expiry.
- `arming` = (state==ARMING) and `running` = (state==RUN); both are registered alongside the state.
- `mode_led` is registered and decoded from the next-state mode, so it updates on the same edge as `mode`.
- Counter widths: $clog2 of the respective parameter plus 1. There are no wrap-arounds other than the defined mode wrap N_MODES→0.

## Timing
- Reset (async assert, sync release through the flops) forces: state IDLE, mode 0, mode_led 0, arming 0, running 0, start_pulse 0, debounced level 0, all counters 0.
- Press latency: a raw edge that stays stable gives a press event on cycle 2 + DEBOUNCE_CYCLES (±1 for metastability). State and outputs update on the next edge.
- ARMING lasts exactly ARM_CYCLES cycles from the entry edge, absent further events. start_pulse is high for exactly one cycle and coincides with the first cycle of running=1.
- Each press in ARMING restarts the full ARM_CYCLES window.
- A button held down produces exactly one press event. No event is generated on release.
- Reset asserted mid-ARMING or mid-RUN takes effect immediately. The car stops, and no start_pulse is issued after reset release.
- stop_i in IDLE is ignored. stop_i on the same cycle as the countdown expiry goes to IDLE with no start_pulse.

## Test plan
Bench parameters: N_MODES=3, DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=20, ARM_CYCLES=50.
- **Bounce:** btn_sel toggles every 2 cycles for 20 cycles, then holds 1 → exactly one press; mode=1, mode_led=3'b001, arming=1.
- **Lockout:** two clean presses 10 cycles apart → mode=1 only. Two presses 30 cycles apart → mode=2, mode_led=3'b010, countdown reloaded.
- **Wrap:** 4 spaced presses → mode goes 1,2,3,0. The final press returns to IDLE, with mode_led=0 and arming=0.
- **Arm/start:** one press, then wait → running=1 exactly 50 cycles after arming rose. start_pulse is high for 1 cycle, and mode_led is held.
- **Abort:** stop_i=1 during RUN, then on the exact expiry cycle of a second ARMING → both go to IDLE with mode=0. The second case produces no start_pulse.
- **Reset:** rst_n=0 mid-ARMING for 3 cycles → all outputs 0 asynchronously, and the design remains in IDLE after release with no spurious press.
